bcd_display_scanner: RTL and testbench
======================================

// Module: bcd_display_scanner
// PURPOSE
//   Time-multiplexes a 4-digit packed-BCD value onto one shared 7-segment decoder.
//   Sits directly upstream of the BCD-to-7-segment decoder.
//   Every refresh tick it selects the next digit, presents that digit's nibble on bcd_out and
//   drives the matching active-low anode.
//   The input value is captured on a load strobe, so the displayed value is stable between updates.
// PARAMETERS
//   REFRESH_DIV  50000  clk cycles per digit slot (1 kHz/digit at 50 MHz); legal range >= 2
//   CNT_W        16     prescaler width; must satisfy 2**CNT_W >= REFRESH_DIV
// PORTS
//   clk         in   1   system clock; all state updates on the rising edge
//   rst         in   1   asynchronous, active-high reset
//   data_in     in   16  packed BCD: [3:0]=digit0 (rightmost) .. [15:12]=digit3 (leftmost)
//   load        in   1   capture strobe for data_in; single-cycle or held
//   bcd_out     out  4   nibble for the currently selected digit; feeds the decoder BCD input
//   an          out  4   anode enables, active-low, one-hot-zero; an[k] drives digit k
//   frame_done  out  1   one-cycle pulse when the scan wraps from digit 3 to digit 0
// BEHAVIOUR
//   Registers:
//     - shadow[15:0]: displayed value
//     - prescaler[CNT_W-1:0]
//     - idx[1:0]: current digit
//     - bcd_out, an, frame_done: all registered; no combinational path from input to output
//   Reset (asynchronous, takes effect immediately, regardless of clk):
//     - shadow=0, prescaler=0, idx=0
//     - bcd_out=4'h0, an=4'b1110, frame_done=0
//   Load:
//     - load=1 at a rising edge sets shadow<=data_in.
//     - The new value appears on bcd_out at the next digit slot boundary; the current slot is
//       never changed mid-slot.
//     - Held load recaptures every cycle.
//   Prescaler:
//     - Counts 0..REFRESH_DIV-1 and wraps to 0.
//     - tick = (prescaler==REFRESH_DIV-1).
//   On the tick edge:
//     - idx<=idx+1 (mod 4, 3 wraps to 0).
//     - bcd_out<=shadow[4*(idx+1)+:4], using the post-load shadow if load is coincident.
//     - an<=~(4'b0001<<(idx+1)).
//     - bcd_out and an change on the same edge, so each slot lasts exactly REFRESH_DIV cycles.
//   frame_done:
//     - Asserted for one cycle on the edge where idx goes 3->0; 0 otherwise.
//   Scan states (idx): D0 -> D1 -> D2 -> D3 -> D0. There are no other states and no stall condition.
//   Nibble values >9 are passed through unmodified; the decoder is responsible for handling them.
//   Reset asserted mid-slot or mid-frame: the scan restarts at D0 with a full REFRESH_DIV-cycle slot
//     after release.
//   Simultaneous load and tick: the capture and the advance both occur, and the new slot shows the
//     newly loaded nibble.
// CONFIGURATION
//   Macro LEADING_ZERO_BLANK_EN:
//     - Defined: when a slot starts on digit k>=1 and shadow digits k..3 are all 4'h0, an<=4'b1111
//       for that slot (digit dark). bcd_out still carries the nibble.
//     - Defined: digit 0 is never blanked, so value 0 shows a single "0".
//     - Blanking is evaluated at slot start against the shadow in effect for that slot.
//     - Not defined: all four digits are always driven; leading zeros are displayed.
// TESTING  (bench uses REFRESH_DIV=4)
//   1. rst=1 for 3 cycles, then release -> an=1110, bcd_out=0, frame_done=0; the first advance
//      occurs on the 4th rising edge after release.
//   2. load data_in=16'h1234, free-run 16 cycles -> sequence (an,bcd_out) = (1110,4), (1101,3),
//      (1011,2), (0111,1), each lasting 4 cycles; frame_done pulses once, on the 0111->1110 edge.
//   3. load 16'h5678 in the 2nd cycle of the D1 slot -> D1 keeps showing 3 until the slot ends;
//      D2 then shows 6.
//   4. load coincident with the tick ending D0 (16'h1234 -> 16'h9ABC) -> D1 slot shows B; nibbles
//      >9 pass through unchanged.
//   5. rst pulsed mid-D2 slot -> an=1110 and bcd_out=0 immediately, without waiting for clk;
//      shadow=0; the scan restarts at D0.
//   6. LEADING_ZERO_BLANK_EN defined, load 16'h0070 -> D3 and D2 slots have an=1111; D1 shows 7;
//      D0 shows 0.
//   6b. LEADING_ZERO_BLANK_EN defined, load 16'h0000 -> only D0 is lit, showing 0.

Source files
------------

// File: rtl/bcd_display_scanner.sv
// Scans a captured 4-digit packed-BCD value onto one shared 7-segment decoder, one digit per slot.
// Optional macro LEADING_ZERO_BLANK_EN darkens leading-zero digits (digit 0 is always lit).
module bcd_display_scanner #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    input  logic        load,
    output logic [3:0]  bcd_out,
    output logic [3:0]  an,
    output logic        frame_done
);

    typedef enum logic [1:0] {D0 = 2'd0, D1 = 2'd1, D2 = 2'd2, D3 = 2'd3} scan_t;

    scan_t            state_q, state_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [CNT_W-1:0] prescaler_q, prescaler_d;
    logic             tick;
    logic [3:0]       bcd_d, an_d;
    logic             frame_d;

    // The slot that starts on a tick sees a coincident load.
    assign shadow_d    = load ? data_in : shadow_q;
    assign tick        = (prescaler_q == CNT_W'(REFRESH_DIV - 1));
    assign prescaler_d = tick ? '0 : prescaler_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= D0;
            shadow_q    <= '0;
            prescaler_q <= '0;
            bcd_out     <= 4'h0;
            an          <= 4'b1110;
            frame_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            prescaler_q <= prescaler_d;
            bcd_out     <= bcd_d;
            an          <= an_d;
            frame_done  <= frame_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            unique case (state_q)
                D0:      state_d = D1;
                D1:      state_d = D2;
                D2:      state_d = D3;
                D3:      state_d = D0;
                default: state_d = D0;
            endcase
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic blank;

    // Dark when this digit and every digit to its left are zero.
    always_comb begin
        blank = 1'b0;
        unique case (state_d)
            D1:      blank = (shadow_d[15:4] == 12'h000);
            D2:      blank = (shadow_d[15:8] == 8'h00);
            D3:      blank = (shadow_d[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
    end
`endif

    always_comb begin
        bcd_d   = bcd_out;
        an_d    = an;
        frame_d = 1'b0;
        if (tick) begin
            bcd_d   = shadow_d[{state_d, 2'b00} +: 4];
            an_d    = ~(4'b0001 << state_d);
            frame_d = (state_q == D3);
`ifdef LEADING_ZERO_BLANK_EN
            if (blank) begin
                an_d = 4'b1111;
            end
`endif
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner with REFRESH_DIV=4; a cycle model feeds a
// scoreboard queue, and scenario tasks add explicit checks of their own.
module tb_bcd_display_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in;
    logic        load;
    logic [3:0]  bcd_out;
    logic [3:0]  an;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] sb[$];

    logic [15:0] m_shadow;
    int          m_cnt;
    int          m_idx;
    logic [3:0]  m_an;
    logic [3:0]  m_bcd;
    logic        m_frame;

    bcd_display_scanner #(
        .REFRESH_DIV(4),
        .CNT_W      (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .load      (load),
        .bcd_out   (bcd_out),
        .an        (an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: compares the expectation pushed before each edge.
    always @(posedge clk) begin
        logic [8:0] exp_v;
        #1;
        if (sb.size() > 0) begin
            exp_v = sb.pop_front();
            n_tests++;
            if ({an, bcd_out, frame_done} !== exp_v) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t got an=%b bcd=%h fd=%b expected an=%b bcd=%h fd=%b",
                         $time, an, bcd_out, frame_done, exp_v[8:5], exp_v[4:1], exp_v[0]);
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    function automatic logic lead_dark(input logic [15:0] v, input int k);
        if (k == 0) return 1'b0;
        for (int j = k; j < 4; j++) begin
            if (((v >> (4 * j)) & 16'h000F) != 16'h0000) return 1'b0;
        end
        return 1'b1;
    endfunction
`endif

    task automatic model_reset();
        m_shadow = '0;
        m_cnt    = 0;
        m_idx    = 0;
        m_an     = 4'b1110;
        m_bcd    = 4'h0;
        m_frame  = 1'b0;
    endtask

    // Advance the model by one edge, queue its outputs, then clock the DUT.
    task automatic cycle();
        logic [15:0] ns;
        int          ni;
        if (rst) begin
            model_reset();
        end else begin
            ns = load ? data_in : m_shadow;
            if (m_cnt == 3) begin
                ni      = (m_idx + 1) % 4;
                m_frame = (m_idx == 3);
                m_bcd   = 4'((ns >> (4 * ni)) & 16'h000F);
                m_an    = ~(4'(1) << ni);
`ifdef LEADING_ZERO_BLANK_EN
                if (lead_dark(ns, ni)) m_an = 4'b1111;
`endif
                m_idx = ni;
                m_cnt = 0;
            end else begin
                m_cnt++;
                m_frame = 1'b0;
            end
            m_shadow = ns;
        end
        sb.push_back({m_an, m_bcd, m_frame});
        @(posedge clk);
        #1;
    endtask

    task automatic scan_to(input int idx, input int cnt);
        int guard = 0;
        while (!(m_idx == idx && m_cnt == cnt) && guard < 40) begin
            cycle();
            guard++;
        end
        n_tests++;
        if (!(m_idx == idx && m_cnt == cnt)) begin
            n_fail++;
            $display("FAIL scan_to timeout: at idx=%0d cnt=%0d, wanted idx=%0d cnt=%0d",
                     m_idx, m_cnt, idx, cnt);
        end
    endtask

    task automatic load_once(input logic [15:0] v);
        data_in = v;
        load    = 1'b1;
        cycle();
        load    = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_an1;
        rst = 1'b1; load = 1'b0; data_in = '0;
        model_reset();
        #2;
        n_tests++;
        if ({an, bcd_out, frame_done} !== {4'b1110, 4'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async got an=%b bcd=%h fd=%b expected an=1110 bcd=0 fd=0",
                     an, bcd_out, frame_done);
        end
        repeat (3) cycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_tests++;
            if (an !== 4'b1110) begin
                n_fail++;
                $display("FAIL reset_hold edge=%0d got an=%b expected 1110", i + 1, an);
            end
        end
        cycle();
`ifdef LEADING_ZERO_BLANK_EN
        exp_an1 = 4'b1111;
`else
        exp_an1 = 4'b1101;
`endif
        n_tests++;
        if (an !== exp_an1 || bcd_out !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_first_advance got an=%b bcd=%h expected an=%b bcd=0",
                     an, bcd_out, exp_an1);
        end
    endtask

    task automatic test_scan();
        int         pulses = 0;
        logic [3:0] exp_an;
        load_once(16'h1234);
        scan_to(3, 3);
        for (int i = 0; i < 16; i++) begin
            cycle();
            exp_an = ~(4'b0001 << (i / 4));
            n_tests++;
            if (an !== exp_an || bcd_out !== 4'(4 - i / 4)) begin
                n_fail++;
                $display("FAIL scan_seq cycle=%0d got an=%b bcd=%h expected an=%b bcd=%h",
                         i, an, bcd_out, exp_an, 4'(4 - i / 4));
            end
            if (frame_done === 1'b1) pulses++;
            if (i == 0) begin
                n_tests++;
                if (frame_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL frame_wrap got fd=%b expected 1", frame_done);
                end
            end
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL frame_count got %0d expected 1", pulses);
        end
    endtask

    task automatic test_midslot_load();
        scan_to(1, 0);
        cycle();
        load_once(16'h5678);
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (bcd_out !== 4'h3 || an !== 4'b1101) begin
                n_fail++;
                $display("FAIL midslot_hold got an=%b bcd=%h expected an=1101 bcd=3", an, bcd_out);
            end
            cycle();
        end
        n_tests++;
        if (bcd_out !== 4'h6 || an !== 4'b1011) begin
            n_fail++;
            $display("FAIL midslot_next got an=%b bcd=%h expected an=1011 bcd=6", an, bcd_out);
        end
    endtask

    task automatic test_coincident_load();
        load_once(16'h1234);
        scan_to(0, 3);
        load_once(16'h9ABC);
        n_tests++;
        if (bcd_out !== 4'hB || an !== 4'b1101) begin
            n_fail++;
            $display("FAIL coincident got an=%b bcd=%h expected an=1101 bcd=b", an, bcd_out);
        end
        scan_to(2, 0);
        n_tests++;
        if (bcd_out !== 4'hA) begin
            n_fail++;
            $display("FAIL passthru_a got bcd=%h expected a", bcd_out);
        end
        scan_to(3, 0);
        n_tests++;
        if (bcd_out !== 4'h9) begin
            n_fail++;
            $display("FAIL passthru_9 got bcd=%h expected 9", bcd_out);
        end
    endtask

    task automatic test_midslot_reset();
        logic [3:0] exp_an1;
        load_once(16'h1234);
        scan_to(2, 1);
        rst = 1'b1;
        #2;
        n_tests++;
        if ({an, bcd_out, frame_done} !== {4'b1110, 4'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_midslot got an=%b bcd=%h fd=%b expected an=1110 bcd=0 fd=0",
                     an, bcd_out, frame_done);
        end
        model_reset();
        #2;
        rst = 1'b0;
        repeat (3) cycle();
        n_tests++;
        if (an !== 4'b1110) begin
            n_fail++;
            $display("FAIL reset_restart got an=%b expected 1110", an);
        end
        cycle();
`ifdef LEADING_ZERO_BLANK_EN
        exp_an1 = 4'b1111;
`else
        exp_an1 = 4'b1101;
`endif
        n_tests++;
        if (an !== exp_an1 || bcd_out !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_shadow got an=%b bcd=%h expected an=%b bcd=0",
                     an, bcd_out, exp_an1);
        end
    endtask

    // exp_an/exp_bcd hold one nibble per slot, slot k in bits [4k+3:4k].
    task automatic test_blank(input logic [15:0] v, input logic [15:0] exp_an,
                              input logic [15:0] exp_bcd);
        int s;
        load_once(v);
        scan_to(3, 3);
        for (int i = 0; i < 16; i++) begin
            cycle();
            s = i / 4;
            n_tests++;
            if (an !== exp_an[4*s +: 4] || bcd_out !== exp_bcd[4*s +: 4]) begin
                n_fail++;
                $display("FAIL blank_%h slot=%0d got an=%b bcd=%h expected an=%b bcd=%h",
                         v, s, an, bcd_out, exp_an[4*s +: 4], exp_bcd[4*s +: 4]);
            end
        end
    endtask

    task automatic test_back_to_back();
        load = 1'b1;
        for (int i = 0; i < 12; i++) begin
            data_in = 16'($urandom);
            cycle();
        end
        load = 1'b0;
        repeat (8) cycle();
    endtask

    initial begin
        test_reset();
        test_scan();
        test_midslot_load();
        test_coincident_load();
        test_midslot_reset();
`ifdef LEADING_ZERO_BLANK_EN
        test_blank(16'h0070, 16'hFFDE, 16'h0070);
        test_blank(16'h0000, 16'hFFFE, 16'h0000);
`else
        test_blank(16'h0070, 16'h7BDE, 16'h0070);
        test_blank(16'h0000, 16'h7BDE, 16'h0000);
`endif
        test_back_to_back();
        #2;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d entries expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
